// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU issue/writeback sequencer: opcodes, FSM states,
// and the shift-amount width.
package alu_seq_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_PASSA = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } seq_state_e;

endpackage

// File: rtl/alu_core_32bit.sv
// Purely combinational 32-bit ALU. Opcodes 12-15 yield zero and raise illegal.
module alu_core_32bit
  import alu_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y,
  output logic        zero,
  output logic        carry,
  output logic        overflow,
  output logic        illegal
);

  logic [32:0]        sum;
  logic [32:0]        diff;
  logic [SHAMT_W-1:0] shamt;

  // Bit 32 of diff is the borrow, i.e. a < b as unsigned values.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHAMT_W-1:0];

  // NOTE: every output of a combinational block gets a default first so
  // no path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    y        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        y        = sum[31:0];
        carry    = sum[32];
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        y        = diff[31:0];
        carry    = diff[32];
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~(a | b);
      OP_SLT:   y = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  y = {31'd0, a < b};
      OP_SLL:   y = a << shamt;
      OP_SRL:   y = a >> shamt;
      OP_SRA:   y = $signed(a) >>> shamt;
      OP_PASSA: y = a;
      default:  illegal = 1'b1;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_op_sequencer_32bit.sv
// Issue/writeback sequencer driving the register file: IDLE -> READ -> EXEC -> WB,
// with a new instruction accepted in WB for one instruction every three cycles.
module alu_op_sequencer_32bit
  import alu_seq_pkg::*;
#(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        op,
  input  logic [RWIDTH-1:0] rs1,
  input  logic [RWIDTH-1:0] rs2,
  input  logic [RWIDTH-1:0] rd,
  output logic [RWIDTH-1:0] ra1,
  output logic [RWIDTH-1:0] ra2,
  output logic [RWIDTH-1:0] wa,
  output logic [DWIDTH-1:0] wd,
  output logic              we,
  input  logic [DWIDTH-1:0] rd1,
  input  logic [DWIDTH-1:0] rd2,
  output logic [DWIDTH-1:0] result,
  output logic              result_valid,
  output logic              zero,
  output logic              carry,
  output logic              overflow,
  output logic              illegal
);

  seq_state_e        state, state_next;
  logic              handshake;
  logic [3:0]        op_q;
  logic [RWIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DWIDTH-1:0] alu_y;
  logic              alu_zero, alu_carry, alu_overflow, alu_illegal;

  // Ready is gated by rst so nothing can be accepted while reset is held.
  assign instr_ready = !rst && (state == S_IDLE || state == S_WB);
  assign handshake   = instr_valid && instr_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (handshake) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = handshake ? S_READ : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else if (handshake) begin
      op_q  <= op;
      rs1_q <= rs1;
      rs2_q <= rs2;
      rd_q  <= rd;
    end
  end

  alu_core_32bit u_alu (
    .a        (rd1),
    .b        (rd2),
    .op       (op_q),
    .y        (alu_y),
    .zero     (alu_zero),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .illegal  (alu_illegal)
  );

  // Result and flags hold until the next EXEC so they remain observable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (state == S_EXEC) begin
      result   <= alu_y;
      zero     <= alu_zero;
      carry    <= alu_carry;
      overflow <= alu_overflow;
      illegal  <= alu_illegal;
    end
  end

  // we decodes straight from state, so an asynchronous reset drops it at once.
  assign ra1          = rs1_q;
  assign ra2          = rs2_q;
  assign wa           = rd_q;
  assign wd           = result;
  assign we           = (state == S_WB);
  assign result_valid = (state == S_WB);

endmodule

// File: tb/tb_alu_op_sequencer_32bit.sv
// Bench for alu_op_sequencer_32bit: behavioural register file, reference ALU
// model feeding a writeback scoreboard, plus directed latency/hazard/reset steps.
module tb_alu_op_sequencer_32bit;

  localparam int RW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid, instr_ready;
  logic [3:0]    op;
  logic [RW-1:0] rs1, rs2, rd, ra1, ra2, wa;
  logic [DW-1:0] wd, rd1, rd2, result;
  logic          we, result_valid, zero, carry, overflow, illegal;

  always #5 clk = ~clk;

  alu_op_sequencer_32bit #(.RWIDTH(RW), .DWIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .op           (op),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .ra1          (ra1),
    .ra2          (ra2),
    .wa           (wa),
    .wd           (wd),
    .we           (we),
    .rd1          (rd1),
    .rd2          (rd2),
    .result       (result),
    .result_valid (result_valid),
    .zero         (zero),
    .carry        (carry),
    .overflow     (overflow),
    .illegal      (illegal)
  );

  // Register file: registered reads, no read while writing.
  logic [DW-1:0] regs     [64];
  logic [DW-1:0] ref_regs [64];

  always @(posedge clk) begin
    if (we) regs[wa] <= wd;
    else begin
      rd1 <= regs[ra1];
      rd2 <= regs[ra2];
    end
  end

  typedef struct {
    logic [RW-1:0] wa;
    logic [DW-1:0] wd;
    logic          zero, carry, overflow, illegal;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            wb_count = 0;
  int            cyc = 0;
  logic [DW-1:0] last_wd = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] opc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [RW-1:0] d);
    exp_t               e;
    longint             va, vb;
    longint unsigned    ua;
    logic signed [31:0] sa;
    va = longint'($signed(a));
    vb = longint'($signed(b));
    ua = longint'(a);
    sa = a;
    e.wa = d; e.carry = 1'b0; e.overflow = 1'b0; e.illegal = 1'b0;
    case (opc)
      4'd0: begin
        e.wd       = a + b;
        e.carry    = ((ua + longint'(b)) >> 32) != 0;
        e.overflow = (va + vb) != longint'($signed(e.wd));
      end
      4'd1: begin
        e.wd       = a - b;
        e.carry    = a < b;
        e.overflow = (va - vb) != longint'($signed(e.wd));
      end
      4'd2:  e.wd = a & b;
      4'd3:  e.wd = a | b;
      4'd4:  e.wd = a ^ b;
      4'd5:  e.wd = ~(a | b);
      4'd6:  e.wd = (va < vb) ? 32'd1 : 32'd0;
      4'd7:  e.wd = (a < b) ? 32'd1 : 32'd0;
      4'd8:  e.wd = a << b[4:0];
      4'd9:  e.wd = a >> b[4:0];
      4'd10: e.wd = sa >>> b[4:0];
      4'd11: e.wd = a;
      default: begin
        e.wd      = 32'd0;
        e.illegal = 1'b1;
      end
    endcase
    e.zero = (e.wd == 32'd0);
    return e;
  endfunction

  // Writeback monitor: every WB cycle must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (we || result_valid)) begin
      exp_t e;
      wb_count++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_wb: observed wa=%h wd=%h expected no writeback", wa, wd);
      end else begin
        e = sb.pop_front();
        check("wb_we",       {31'd0, we},           32'd1);
        check("wb_valid",    {31'd0, result_valid}, 32'd1);
        check("wb_wa",       {26'd0, wa},           {26'd0, e.wa});
        check("wb_wd",       wd,                    e.wd);
        check("wb_result",   result,                e.wd);
        check("wb_zero",     {31'd0, zero},         {31'd0, e.zero});
        check("wb_carry",    {31'd0, carry},        {31'd0, e.carry});
        check("wb_overflow", {31'd0, overflow},     {31'd0, e.overflow});
        check("wb_illegal",  {31'd0, illegal},      {31'd0, e.illegal});
        last_wd = wd;
      end
    end
  end

  // Call just after a negedge; returns right after the handshake edge with valid still high.
  task automatic send(input logic [3:0] o, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                      input logic [RW-1:0] d, input bit push, output int hs_cyc);
    exp_t e;
    instr_valid = 1'b1;
    op = o; rs1 = s1; rs2 = s2; rd = d;
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
    if (!instr_ready) check("send_timeout", {31'd0, instr_ready}, 32'd1);
    hs_cyc = cyc;
    if (push) begin
      e = model(o, ref_regs[s1], ref_regs[s2], d);
      sb.push_back(e);
      ref_regs[d] = e.wd;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !we) break;
      @(negedge clk);
    end
    check("drain_sb_empty", sb.size(), 32'd0);
  endtask

  task automatic do_op(input logic [3:0] o, input logic [RW-1:0] s1,
                       input logic [RW-1:0] s2, input logic [RW-1:0] d);
    int h;
    send(o, s1, s2, d, 1'b1, h);
    drain();
  endtask

  // Directed result/flag check taken in the WB cycle.
  task automatic op_expect(input string tag, input logic [3:0] o, input logic [RW-1:0] s1,
                           input logic [RW-1:0] s2, input logic [RW-1:0] d,
                           input logic [31:0] exp_y, input logic [3:0] zcvi);
    int h;
    send(o, s1, s2, d, 1'b1, h);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 10 && !result_valid; i++) @(negedge clk);
    check({tag, "_result"}, result, exp_y);
    check({tag, "_flags"}, {28'd0, zero, carry, overflow, illegal}, {28'd0, zcvi});
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int h1, h2, n0;
    for (int i = 0; i < 64; i++) begin
      regs[i]     = 32'hA000_0000 | i;
      ref_regs[i] = 32'hA000_0000 | i;
    end
    regs[40] = 32'd5;          regs[41] = 32'd7;
    regs[42] = 32'd0;          regs[43] = 32'd1;
    regs[44] = 32'h7FFF_FFFF;  regs[45] = 32'h8000_0000;
    regs[46] = 32'hFFFF_FFFF;  regs[47] = 32'd4;
    for (int i = 40; i < 48; i++) ref_regs[i] = regs[i];

    rst = 1'b1; instr_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (2) @(negedge clk);
    check("rst_ready",   {31'd0, instr_ready}, 32'd0);
    check("rst_we",      {31'd0, we},          32'd0);
    check("rst_valid",   {31'd0, result_valid}, 32'd0);
    check("rst_addrs",   {14'd0, ra1, ra2, wa}, 32'd0);
    check("rst_wd",      wd,     32'd0);
    check("rst_result",  result, 32'd0);
    check("rst_flags",   {28'd0, zero, carry, overflow, illegal}, 32'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", {31'd0, instr_ready}, 32'd1);

    // Seed r1/r2 through PASSA chains.
    do_op(4'd11, 6'd40, 6'd0, 6'd1);
    do_op(4'd11, 6'd41, 6'd0, 6'd2);

    // ADD r3 = r1 + r2 with cycle-accurate latency.
    send(4'd0, 6'd1, 6'd2, 6'd3, 1'b1, h1);
    @(negedge clk);
    instr_valid = 1'b0;
    check("lat_read_valid", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    check("lat_exec_valid", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    check("lat_wb_we",   {31'd0, we}, 32'd1);
    check("lat_wb_wa",   {26'd0, wa}, 32'd3);
    check("lat_wb_wd",   wd,          32'd12);
    check("lat_wb_zero", {31'd0, zero}, 32'd0);
    drain();
    op_expect("readback_r3", 4'd11, 6'd3, 6'd0, 6'd6, 32'd12, 4'b0000);

    op_expect("sub_borrow", 4'd1, 6'd42, 6'd43, 6'd12, 32'hFFFF_FFFF, 4'b0100);
    op_expect("add_ovf",    4'd0, 6'd44, 6'd43, 6'd13, 32'h8000_0000, 4'b0010);

    // Back-to-back with RAW hazard on r4.
    send(4'd0, 6'd1, 6'd2, 6'd4, 1'b1, h1);
    @(negedge clk);
    send(4'd0, 6'd4, 6'd4, 6'd5, 1'b1, h2);
    check("b2b_gap", h2 - h1, 32'd3);
    drain();
    check("b2b_r5", last_wd, 32'd24);

    op_expect("sra",     4'd10, 6'd45, 6'd47, 6'd15, 32'hF800_0000, 4'b0000);
    op_expect("slt",     4'd6,  6'd46, 6'd43, 6'd16, 32'd1,         4'b0000);
    op_expect("sltu",    4'd7,  6'd46, 6'd43, 6'd17, 32'd0,         4'b1000);
    op_expect("illegal", 4'd13, 6'd40, 6'd41, 6'd18, 32'd0,         4'b1001);

    // Every opcode over random seeded operands.
    for (int i = 0; i < 16; i++)
      do_op(4'(i), 6'($urandom_range(40, 47)), 6'($urandom_range(40, 47)), 6'(24 + i));

    // Reset during EXEC: instruction lost, r7 untouched.
    send(4'd0, 6'd1, 6'd2, 6'd7, 1'b0, h1);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_we",    {31'd0, we},          32'd0);
    check("abort_ready", {31'd0, instr_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_hold_we", {31'd0, we}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_idle_ready", {31'd0, instr_ready}, 32'd1);
    check("abort_result",     result,               32'd0);
    do_op(4'd11, 6'd7, 6'd0, 6'd19);
    check("abort_r7_kept", last_wd, 32'hA000_0007);

    // instr_valid raised during READ/EXEC is ignored.
    send(4'd0, 6'd1, 6'd2, 6'd20, 1'b1, h1);
    n0 = wb_count;
    @(negedge clk);
    instr_valid = 1'b1; op = 4'd1; rd = 6'd21;
    check("pulse_read_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check("pulse_exec_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check("pulse_wb_count", wb_count - n0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer_32bit.md
# alu_op_sequencer_32bit

Issue-and-writeback sequencer that sits directly in front of the 32-bit register file and drives all of its ports. It accepts one register-register ALU instruction per handshake, reads both source operands through the register file's registered read path, executes the operation in an internal ALU, and writes the result back to the destination register. The block and the register file are the core datapath of the 32-bit processor.

## Interface
- RWIDTH, 6, register address width (2**RWIDTH registers)
- DWIDTH, 32, data width; the ALU and flag logic support only 32
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- op  in  4  ALU opcode
- rs1, rs2  in  RWIDTH  source register addresses
- rd  in  RWIDTH  destination register address
- ra1, ra2  out  RWIDTH  register file read addresses
- wa  out  RWIDTH  register file write address
- wd  out  DWIDTH  register file write data
- we  out  1  register file write enable
- rd1, rd2  in  DWIDTH  register file read data, registered by the register file
- result  out  DWIDTH  last computed result, held until the next EXEC
- result_valid  out  1  one-cycle pulse during writeback
- zero, carry, overflow, illegal  out  1  flags for the last result, held like result

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- instr_ready is 1 in IDLE and WB and 0 in READ and EXEC. Handshake: instr_valid && instr_ready at a rising edge.
- IDLE: on handshake, latch op, rs1, rs2 and rd, then go to READ. Otherwise stay in IDLE.
- READ: ra1 = latched rs1, ra2 = latched rs2, we = 0. The register file captures rd1 and rd2 at the end of this cycle. Go to EXEC.
- EXEC: rd1 and rd2 are valid. Compute, then register result and flags at the end of the cycle. Go to WB.
- WB: we = 1, wa = latched rd, wd = result, result_valid = 1. On handshake, latch the new instruction and go to READ. Otherwise go to IDLE.
- we is asserted only in WB. The register file does not update rd1 and rd2 while we = 1, and no read is needed in that cycle.
- Read-after-write hazard: the write commits at the WB→READ edge. The next READ captures at the edge after that, so it returns the new value. No forwarding logic.
- No hard-wired zero register. All 2**RWIDTH registers are writable.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA, with shift amount rd2[4:0]
  - 11 PASSA (result = rd1)
  - 12–15: result = 0, illegal = 1, writeback still occurs
- Flags:
  - zero = (result == 0) for every opcode.
  - carry = carry-out for ADD; borrow (rd1 < rd2 unsigned) for SUB; 0 otherwise.
  - overflow = signed overflow for ADD and SUB only; 0 otherwise.
  - SLT and SLTU produce 32'h1 or 32'h0.

## Timing
- Reset values (asynchronous): state = IDLE, instr_ready = 0 while rst is high, all address outputs = 0, wd = 0, we = 0, result = 0, all flags = 0, result_valid = 0. instr_ready becomes 1 in the first cycle after rst falls.
- Latency: handshake at edge N → READ in cycle N+1 → EXEC in N+2 → WB in N+3. The write commits at edge N+4.
- Sustained throughput is one instruction per 3 cycles when instr_valid is held high (WB→READ back-to-back).
- Reset asserted mid-operation aborts immediately and drops we asynchronously. No partial write occurs, and the instruction is lost.
- instr_valid deasserting outside a handshake has no effect. Inputs are sampled only at a handshake edge.

## Structure
- Package alu_seq_pkg holds:
  - opcode enum alu_op_e (4-bit, values above)
  - state enum seq_state_e
  - localparam SHAMT_W = 5
- Sub-module alu_core_32bit: purely combinational. Inputs a, b, op; outputs y, zero, carry, overflow, illegal. The sequencer registers its outputs in EXEC.

## Test plan
- Reset, then write values via PASSA chains. ADD with r1 = 5, r2 = 7, rd = r3 → WB 3 cycles after handshake: we = 1, wa = 3, wd = 12, zero = 0. A later read of r3 returns 12.
- SUB with 0x0 − 0x1 → result 0xFFFFFFFF, carry = 1, overflow = 0. ADD 0x7FFFFFFF + 1 → 0x80000000, overflow = 1.
- Back-to-back, instr_valid held high: ADD r4 = r1 + r2, then ADD r5 = r4 + r4 → second handshake during WB, instructions 3 cycles apart, r5 = 24 (hazard resolved).
- SRA 0x80000000 by 4 → 0xF8000000. SLT −1 vs 1 → 1. SLTU −1 vs 1 → 0. Opcode 13 → result 0, illegal = 1, zero = 1.
- Assert rst during EXEC → we never pulses, state IDLE, and the destination register keeps its old value.
- Handshake with instr_valid pulsed in READ or EXEC → ignored (instr_ready = 0). Only one writeback is observed.
